// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state type, default widths and helpers for mem_arbiter
package mem_arb_pkg;

   localparam int ARB_ADDR_W = 8;
   localparam int ARB_DATA_W = 8;
   localparam logic [15:0] STALL_CT_MAX = 16'hFFFF;

   // Previous-cycle owner of the data memory port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CORE = 2'd1,
      ST_HOST = 2'd2,
      ST_LOCK = 2'd3
   } arb_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == STALL_CT_MAX) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of consecutive denied host cycles
module arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic host_req,
   input  logic host_gnt,
   output logic starved
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (host_req && !host_gnt) begin
         if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   assign starved = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (core/host) data memory arbiter; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int ADDR_W     = ARB_ADDR_W,
   parameter int DATA_W     = ARB_DATA_W
) (
   input  logic              CLK,
   input  logic              start,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              host_lock,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       stall_ct
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic              core_win;
   logic              host_win;
   logic              core_rv_q;
   logic              host_rv_q;
   logic [DATA_W-1:0] core_rd_q;
   logic [DATA_W-1:0] host_rd_q;
   logic [15:0]       stall_q;

`ifndef MEM_ARB_RR_EN
   logic starved;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk      (CLK),
      .rst      (start),
      .host_req (host_req),
      .host_gnt (host_win),
      .starved  (starved)
   );
`endif

   always_ff @(posedge CLK) begin
      if (start) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      core_win = 1'b0;
      host_win = 1'b0;
      state_d  = ST_IDLE;
      if (!start) begin
         if (state_q == ST_LOCK && host_req && host_lock) begin
            host_win = 1'b1;
         end else if (core_req && host_req) begin
`ifdef MEM_ARB_RR_EN
            // Favour whichever port did not own the memory last cycle.
            host_win = (state_q == ST_CORE);
`else
            host_win = starved;
`endif
            core_win = ~host_win;
         end else begin
            core_win = core_req;
            host_win = host_req;
         end
      end
      if (core_win) begin
         state_d = ST_CORE;
      end else if (host_win) begin
         state_d = host_lock ? ST_LOCK : ST_HOST;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (core_win) begin
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_read  = ~core_we;
         mem_write = core_we;
      end else if (host_win) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_read  = ~host_we;
         mem_write = host_we;
      end
   end

   // Read data is captured at the grant edge; rdata holds until the port's next read.
   always_ff @(posedge CLK) begin
      if (start) begin
         core_rv_q <= 1'b0;
         host_rv_q <= 1'b0;
         core_rd_q <= '0;
         host_rd_q <= '0;
         stall_q   <= '0;
      end else begin
         core_rv_q <= core_win & ~core_we;
         host_rv_q <= host_win & ~host_we;
         if (core_win && !core_we) begin
            core_rd_q <= mem_rdata;
         end
         if (host_win && !host_we) begin
            host_rd_q <= mem_rdata;
         end
         if (core_stall) begin
            stall_q <= sat_inc16(stall_q);
         end
      end
   end

   assign core_gnt    = core_win;
   assign host_gnt    = host_win;
   assign core_stall  = core_req & ~core_win & ~start;
   assign core_rvalid = core_rv_q & ~start;
   assign host_rvalid = host_rv_q & ~start;
   assign core_rdata  = core_rd_q;
   assign host_rdata  = host_rd_q;
   assign stall_ct    = stall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;

   localparam int SMAX = 4;

   logic       CLK = 1'b0;
   logic       start;
   logic       core_req, core_we, core_gnt, core_stall, core_rvalid;
   logic [7:0] core_addr, core_wdata, core_rdata;
   logic       host_req, host_we, host_gnt, host_rvalid, host_lock;
   logic [7:0] host_addr, host_wdata, host_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_read, mem_write;
   logic [15:0] stall_ct;

   logic [7:0] mem [256];
   int checks = 0;
   int errors = 0;

   // Behavioural model: last owner (0 none, 1 core, 2 host), lock held, starvation, stall count.
   int   m_owner;
   bit   m_locked;
   int   m_starve;
   int   m_stall;
   bit   e_cg, e_hg, e_crv, e_hrv;
   logic [7:0] e_crd, e_hrd;

   always #5 CLK = ~CLK;

   assign mem_rdata = mem[mem_addr];
   always @(posedge CLK) if (mem_write) mem[mem_addr] <= mem_wdata;

   mem_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(8), .DATA_W(8)) dut (
      .CLK(CLK), .start(start),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .host_lock(host_lock),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .stall_ct(stall_ct)
   );

   function automatic void predict();
      e_cg = 1'b0;
      e_hg = 1'b0;
      if (start) return;
      if (m_locked && host_req && host_lock) e_hg = 1'b1;
      else if (core_req && host_req) begin
`ifdef MEM_ARB_RR_EN
         if (m_owner == 1) e_hg = 1'b1; else e_cg = 1'b1;
`else
         if (m_starve == SMAX) e_hg = 1'b1; else e_cg = 1'b1;
`endif
      end else begin
         e_cg = core_req;
         e_hg = host_req;
      end
   endfunction

   task automatic advance();
      predict();
      if (start) begin
         m_owner = 0; m_locked = 0; m_starve = 0; m_stall = 0;
         e_crv = 0; e_hrv = 0; e_crd = 8'h00; e_hrd = 8'h00;
      end else begin
         e_crv = e_cg && !core_we;
         if (e_crv) e_crd = mem[core_addr];
         e_hrv = e_hg && !host_we;
         if (e_hrv) e_hrd = mem[host_addr];
         if (core_req && !e_cg && m_stall < 65535) m_stall++;
         if (host_req && !e_hg) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
         else m_starve = 0;
         m_owner  = e_cg ? 1 : (e_hg ? 2 : 0);
         m_locked = e_hg && host_lock;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                        input bit hr, input bit hw, input logic [7:0] ha, input logic [7:0] hd,
                        input bit hl);
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
   endtask

   task automatic do_reset();
      start = 1'b1;
      drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      advance();
      start = 1'b0;
   endtask

   task automatic test_reset();
      start = 1'b1;
      drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1);
      advance();
      advance();
      @(negedge CLK);
      checks++;
      if ({core_gnt, host_gnt, core_stall} !== 3'b000) begin
         errors++; $display("FAIL reset_gnt got %b want 000", {core_gnt, host_gnt, core_stall});
      end
      checks++;
      if ({mem_read, mem_write, core_rvalid, host_rvalid} !== 4'b0000) begin
         errors++; $display("FAIL reset_mem_rv got %b want 0000", {mem_read, mem_write, core_rvalid, host_rvalid});
      end
      checks++;
      if (stall_ct !== 16'h0000 || core_rdata !== 8'h00 || host_rdata !== 8'h00) begin
         errors++; $display("FAIL reset_regs got stall_ct=%h rdata=%h/%h want 0", stall_ct, core_rdata, host_rdata);
      end
      advance();
   endtask

   task automatic test_write_read();
      do_reset();
      drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A, 0);
      @(negedge CLK);
      checks++;
      if ({host_gnt, mem_write, mem_read, mem_addr, mem_wdata} !== {3'b110, 8'h10, 8'h5A}) begin
         errors++; $display("FAIL host_write got gnt=%b we=%b rd=%b a=%h d=%h want 1 1 0 10 5a",
                            host_gnt, mem_write, mem_read, mem_addr, mem_wdata);
      end
      advance();
      drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      @(negedge CLK);
      checks++;
      if ({core_gnt, mem_read, mem_write, core_rvalid} !== 4'b1100) begin
         errors++; $display("FAIL core_read_issue got %b want 1100", {core_gnt, mem_read, mem_write, core_rvalid});
      end
      advance();
      drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      @(negedge CLK);
      checks++;
      if (core_rvalid !== 1'b1 || core_rdata !== 8'h5A) begin
         errors++; $display("FAIL core_read_data got rvalid=%b rdata=%h want 1 5a", core_rvalid, core_rdata);
      end
      advance();
      @(negedge CLK);
      checks++;
      if (core_rvalid !== 1'b0 || core_rdata !== 8'h5A) begin
         errors++; $display("FAIL core_rdata_hold got rvalid=%b rdata=%h want 0 5a", core_rvalid, core_rdata);
      end
      advance();
   endtask

   task automatic test_conflict();
      bit want_host;
      int host_cycles = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 8'($urandom), 8'h00, 1, 0, 8'($urandom), 8'h00, 0);
`ifdef MEM_ARB_RR_EN
         want_host = (i % 2 == 1);
`else
         want_host = (i % (SMAX + 1) == SMAX);
`endif
         @(negedge CLK);
         checks++;
         if ({core_gnt, host_gnt} !== {!want_host, want_host}) begin
            errors++; $display("FAIL conflict_c%0d got core=%b host=%b want core=%b host=%b",
                               i, core_gnt, host_gnt, !want_host, want_host);
         end
         if (want_host) host_cycles++;
         advance();
      end
      drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      @(negedge CLK);
      checks++;
      if (stall_ct !== 16'(host_cycles)) begin
         errors++; $display("FAIL conflict_stall_ct got %0d want %0d", stall_ct, host_cycles);
      end
      advance();
   endtask

   task automatic test_lock();
      int bad = 0;
      do_reset();
      drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1);
      advance();
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 8'h30, 8'h00, 1, 0, 8'(8'h21 + i), 8'h00, 1);
         @(negedge CLK);
         if ({core_gnt, host_gnt, core_stall} !== 3'b011) bad++;
         advance();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL lock_hold got %0d bad cycles want 0", bad);
      end
      drive(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      @(negedge CLK);
      checks++;
      if (core_gnt !== 1'b1 || stall_ct !== 16'd6) begin
         errors++; $display("FAIL lock_exit got core_gnt=%b stall_ct=%0d want 1 6", core_gnt, stall_ct);
      end
      advance();
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 1);
      advance();
      start = 1'b1;
      @(negedge CLK);
      checks++;
      if ({host_gnt, host_rvalid} !== 2'b00) begin
         errors++; $display("FAIL midlock_reset got gnt=%b rvalid=%b want 0 0", host_gnt, host_rvalid);
      end
      advance();
      start = 1'b0;
      drive(1, 0, 8'h41, 8'h00, 1, 0, 8'h42, 8'h00, 1);
      @(negedge CLK);
      checks++;
      if ({core_gnt, host_gnt, host_rvalid} !== 3'b100) begin
         errors++; $display("FAIL after_reset_idle got %b want 100", {core_gnt, host_gnt, host_rvalid});
      end
      advance();
   endtask

   task automatic test_random();
      bit er, ew;
      logic [7:0] ea, ed;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), 8'($urandom_range(0, 15)), 8'($urandom),
               $urandom_range(0, 9) < 7, $urandom_range(0, 1), 8'($urandom_range(0, 15)), 8'($urandom),
               $urandom_range(0, 9) < 3);
         predict();
         er = (e_cg && !core_we) || (e_hg && !host_we);
         ew = (e_cg && core_we) || (e_hg && host_we);
         ea = e_cg ? core_addr : (e_hg ? host_addr : 8'h00);
         ed = e_cg ? core_wdata : (e_hg ? host_wdata : 8'h00);
         @(negedge CLK);
         checks++;
         if ({core_gnt, host_gnt, core_stall} !== {e_cg, e_hg, core_req && !e_cg}) begin
            errors++; $display("FAIL rand_gnt c%0d got %b want %b", i, {core_gnt, host_gnt, core_stall},
                               {e_cg, e_hg, core_req && !e_cg});
         end
         checks++;
         if ({mem_read, mem_write, mem_addr, mem_wdata} !== {er, ew, ea, ed}) begin
            errors++; $display("FAIL rand_mem c%0d got %b %b %h %h want %b %b %h %h", i,
                               mem_read, mem_write, mem_addr, mem_wdata, er, ew, ea, ed);
         end
         checks++;
         if ({core_rvalid, host_rvalid, core_rdata, host_rdata} !== {e_crv, e_hrv, e_crd, e_hrd}) begin
            errors++; $display("FAIL rand_read c%0d got %b %b %h %h want %b %b %h %h", i,
                               core_rvalid, host_rvalid, core_rdata, host_rdata, e_crv, e_hrv, e_crd, e_hrd);
         end
         checks++;
         if (stall_ct !== 16'(m_stall)) begin
            errors++; $display("FAIL rand_stall_ct c%0d got %0d want %0d", i, stall_ct, m_stall);
         end
         advance();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00, 1);
      advance();
      drive(1, 0, 8'h51, 8'h00, 1, 0, 8'h50, 8'h00, 1);
      for (int i = 0; i < 65534; i++) advance();
      @(negedge CLK);
      checks++;
      if (stall_ct !== 16'hFFFE) begin
         errors++; $display("FAIL stall_ct_near_max got %h want fffe", stall_ct);
      end
      for (int i = 0; i < 3; i++) advance();
      @(negedge CLK);
      checks++;
      if (stall_ct !== 16'hFFFF || 16'(m_stall) !== 16'hFFFF) begin
         errors++; $display("FAIL stall_ct_saturate got %h want ffff", stall_ct);
      end
      advance();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      m_owner = 0; m_locked = 0; m_starve = 0; m_stall = 0;
      e_crv = 0; e_hrv = 0; e_crd = 8'h00; e_hrd = 8'h00;
      start = 1'b1;
      drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      test_reset();
      test_write_read();
      test_conflict();
      test_lock();
      test_reset_mid_lock();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
